key_expand_ctrl: RTL
====================

Name: key_expand_ctrl

Overview:
Sequencer for AES-128 key expansion. Accepts a 128-bit cipher key and steps a round counter r = 1..NR, selecting the round constant for each round. It streams round keys 0..NR to the cipher round datapath over a valid/ready handshake, one key per accepted transfer. SubWord is performed by four S-box instances outside the block, reached through a combinational port pair, so the S-box logic can be shared with the datapath.

Parameters:
NR, 10, number of expansion rounds; legal range 1..10; keys 0..NR are emitted.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request expansion; sampled only in IDLE
key_in  input  128  cipher key, word w0 = [127:96]; sampled on accepted start
sw_in  output  32  SubWord input = RotWord(w3 of current key), combinational from key register
sw_out  input  32  SubWord result from external S-boxes, combinational, same cycle
round_key  output  128  current round key
rk_idx  output  4  index of round_key, 0..NR
rk_valid  output  1  round_key/rk_idx valid
rk_ready  input  1  consumer accepts round_key when rk_valid & rk_ready
busy  output  1  high from accepted start until final key accepted
done  output  1  one-cycle pulse on the cycle the key with rk_idx = NR is accepted

Behaviour:
- Reset (asynchronous, rst_n low): state = IDLE, round_key = 0, rk_idx = 0, rk_valid = 0, busy = 0, done = 0. Reset asserted mid-expansion aborts immediately. No partial key is output after reset is released.
- States: IDLE, EMIT.
- IDLE: if start = 1 at the clock edge, load round_key <= key_in, set rk_idx <= 0, rk_valid <= 1, busy <= 1, and go to EMIT. Otherwise hold. start is ignored in EMIT; it is not queued.
- EMIT, transfer (rk_valid & rk_ready):
  - If rk_idx < NR: the next clock loads the next round key and sets rk_idx <= rk_idx+1. rk_valid stays 1.
  - If rk_idx = NR: done = 1 for that cycle (combinational from transfer with rk_idx = NR). The next clock clears rk_valid and busy, sets rk_idx <= 0, and returns to IDLE. round_key keeps its last value.
- EMIT, no transfer (rk_ready = 0): round_key, rk_idx and rk_valid hold unchanged (stall, any length).
- Throughput: with rk_ready tied high, key k appears k+1 cycles after the start edge. The final key (idx NR) appears NR+1 cycles after the start edge. A new start is accepted no earlier than the cycle after the return to IDLE.
- Next-key arithmetic, with {w0,w1,w2,w3} = round_key and r = rk_idx+1:
  - sw_in = {w3[23:0], w3[31:24]}
  - t = sw_out ^ rcon(r)
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2; next round_key = {n0,n1,n2,n3}
- rcon(r) byte in bits [31:24], other bytes 0: r = 1..10 gives 01,02,04,08,10,20,40,80,1b,36. Any other r gives 0; it is never used in legal operation.
- sw_in is driven in every state. It is a don't-care outside EMIT.
- rk_ready is ignored while rk_valid = 0.

Test Plan:
- FIPS-197 vector, rk_ready = 1: key_in = 2b7e151628aed2a6abf7158809cf4f3c, start pulse -> idx0 = key_in, idx1 = a0fafe1788542cb123a339392a6c7605, idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6. Keys come on 11 consecutive cycles, done pulses once with idx 10, busy falls the next cycle.
- Backpressure: same key, rk_ready low for 3 cycles at idx 4 -> round_key and rk_idx stable during the stall, no skipped or duplicated index, final keys identical to the unstalled run.
- start pulsed while busy at idx 5 with a different key_in -> ignored, sequence completes with the original key. A start the cycle after done's return to IDLE is accepted.
- Asynchronous reset asserted mid-cycle at idx 6 -> outputs 0 immediately without a clock edge. After release, a fresh start with key 000102030405060708090a0b0c0d0e0f yields idx10 = 13111d7fe3944a17f307a78b4d2b30c5.
- NR = 1 build: FIPS key -> exactly two keys (idx0, idx1 = a0fafe17...), done with idx 1.
- Idle hold: start = 0 for 20 cycles after reset -> rk_valid, busy and done remain 0.

Source files
------------

// File: rtl/key_expand_ctrl.sv
// AES-128 key-expansion sequencer: streams round keys 0..NR, one per accepted transfer.
// Latency: key 0 is valid the cycle after the start edge, then one new key per transfer.
// Backpressure: rk_ready low holds round_key/rk_idx/rk_valid for any number of cycles.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start, key_in       expansion request and cipher key (w0 = [127:96]), sampled in IDLE
//   sw_in, sw_out       RotWord(w3) out to the shared S-boxes, SubWord result back (same cycle)
//   round_key, rk_idx   current round key and its index 0..NR
//   rk_valid, rk_ready  output handshake
//   busy, done          busy from accepted start to final transfer; done pulses on final transfer
module key_expand_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic [31:0]  sw_in,
    input  logic [31:0]  sw_out,
    output logic [127:0] round_key,
    output logic [3:0]   rk_idx,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy,
    output logic         done
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NR);

    state_t state;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  t, n0, n1, n2, n3;
    logic [3:0]   rnd;
    logic [127:0] next_key;
    logic         xfer;

    // Round constant for round r; zero outside 1..10 (never reached when NR is legal).
    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    assign {w0, w1, w2, w3} = round_key;
    assign rnd   = rk_idx + 4'd1;

    // RotWord goes out to the shared S-boxes; SubWord comes back combinationally.
    assign sw_in = {w3[23:0], w3[31:24]};
    assign t     = sw_out ^ {rcon(rnd), 24'h000000};

    // Each new word chains off the previous new word.
    assign n0       = w0 ^ t;
    assign n1       = w1 ^ n0;
    assign n2       = w2 ^ n1;
    assign n3       = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};

    assign xfer = rk_valid & rk_ready;
    assign done = (state == EMIT) & xfer & (rk_idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            round_key <= '0;
            rk_idx    <= '0;
            rk_valid  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        round_key <= key_in;
                        rk_idx    <= '0;
                        rk_valid  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (xfer) begin
                        if (rk_idx == LAST_IDX) begin
                            // round_key deliberately keeps the final key.
                            rk_valid <= 1'b0;
                            busy     <= 1'b0;
                            rk_idx   <= '0;
                            state    <= IDLE;
                        end else begin
                            round_key <= next_key;
                            rk_idx    <= rnd;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
